// File: rtl/reg_file_p.sv
// ----------------------------------------------------------------------------
// reg_file_p
//
// Parametrised register file: DEPTH entries of WIDTH bits, one synchronous
// write port, two combinational read ports, optional hardwired-zero r0 and a
// sequenced clear engine that zeroes one entry per cycle.
//
// Parameters:
//   WIDTH    register data width in bits
//   DEPTH    number of registers (2..256, need not be a power of two)
//   ZERO_R0  when nonzero, register 0 reads 0 and ignores writes
//   AW       address width, derived from DEPTH
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   reset      synchronous active-high reset (registers, clear engine)
//   wr         write request
//   wr_addr    write address
//   d_in       write data
//   wr_ack     combinational, high when the current write is accepted
//   rd_addr_a  read address, port A
//   rd_addr_b  read address, port B
//   d_out_a    combinational read data, port A
//   d_out_b    combinational read data, port B
//   clr        single-cycle pulse that starts a clear sweep
//   busy       high while a sweep is in progress
//
// Build option:
//   REG_FILE_P_BYPASS_EN  when defined, an accepted write is forwarded to any
//                         read port addressing the same entry in that cycle.
// ----------------------------------------------------------------------------
module reg_file_p #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 8,
    parameter int ZERO_R0 = 0,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] d_in,
    output logic             wr_ack,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] d_out_a,
    output logic [WIDTH-1:0] d_out_b,
    input  logic             clr,
    output logic             busy
);

    localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    state_t           state;
    logic [AW-1:0]    ptr;
    logic [WIDTH-1:0] regs [DEPTH];

    // Addresses at or beyond DEPTH exist only when DEPTH is not a power of two.
    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < DEPTH_W;
    endfunction

    function automatic logic is_zero_reg(input logic [AW-1:0] a);
        return (ZERO_R0 != 0) && (a == '0);
    endfunction

    assign busy = (state == SWEEP);

    // Writes are refused while sweeping so the sweep always leaves a clean file.
    assign wr_ack = wr && !busy && in_range(wr_addr) && !is_zero_reg(wr_addr);

    // Storage and clear engine. A write accepted in the same IDLE cycle as clr
    // still commits; the sweep that follows then zeroes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            state <= IDLE;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_ack) begin
                        regs[wr_addr] <= d_in;
                    end
                    if (clr) begin
                        state <= SWEEP;
                        ptr   <= '0;
                    end
                end
                SWEEP: begin
                    regs[ptr] <= '0;
                    if (ptr == LAST_PTR) begin
                        state <= IDLE;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ptr   <= '0;
                end
            endcase
        end
    end

    // Read port A. Out-of-range and hardwired-zero rules take priority over
    // forwarding; wr_ack already excludes those addresses for the write side.
    always_comb begin
        d_out_a = '0;
        if (in_range(rd_addr_a) && !is_zero_reg(rd_addr_a)) begin
            d_out_a = regs[rd_addr_a];
`ifdef REG_FILE_P_BYPASS_EN
            if (wr_ack && (rd_addr_a == wr_addr)) begin
                d_out_a = d_in;
            end
`endif
        end
    end

    // Read port B, same rules as port A.
    always_comb begin
        d_out_b = '0;
        if (in_range(rd_addr_b) && !is_zero_reg(rd_addr_b)) begin
            d_out_b = regs[rd_addr_b];
`ifdef REG_FILE_P_BYPASS_EN
            if (wr_ack && (rd_addr_b == wr_addr)) begin
                d_out_b = d_in;
            end
`endif
        end
    end

endmodule
